instruction_decode: RTL and testbench

ID stage of the 5-stage RV32I pipeline. Consumes the IF/ID pipeline registers (pc, instr) and decodes the instruction. Owns the 32x32 register file, the immediate generator, the main control decoder and load-use hazard detection. Drives the pc_write/pipeline_reg_write stall controls back to IF and registers all decoded fields into the ID/EX pipeline registers.

---
 rtl/instruction_decode.sv | 234 +++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode
// Description : RV32I ID stage: register file, immediate generation, control
//               decode, load-use stall and the ID/EX pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_pipe,
    input  logic [31:0]           if_id_pc,
    input  logic [31:0]           if_id_instr,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  id_ex_mem_read_in,
    input  logic [REG_ADDR_W-1:0] id_ex_rd_in,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic [31:0]           id_ex_pc,
    output logic [XLEN-1:0]       id_ex_rs1_data,
    output logic [XLEN-1:0]       id_ex_rs2_data,
    output logic [XLEN-1:0]       id_ex_imm,
    output logic [REG_ADDR_W-1:0] id_ex_rs1,
    output logic [REG_ADDR_W-1:0] id_ex_rs2,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic [2:0]            id_ex_funct3,
    output logic                  id_ex_funct7b5,
    output logic                  id_ex_reg_write,
    output logic                  id_ex_mem_read,
    output logic                  id_ex_mem_write,
    output logic                  id_ex_mem_to_reg,
    output logic                  id_ex_alu_src,
    output logic                  id_ex_branch,
    output logic [1:0]            id_ex_alu_op
);

    localparam int          c_NREGS    = 1 << REG_ADDR_W;
    localparam logic [6:0]  c_OP_R     = 7'b0110011;
    localparam logic [6:0]  c_OP_IALU  = 7'b0010011;
    localparam logic [6:0]  c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  c_OP_STORE = 7'b0100011;
    localparam logic [6:0]  c_OP_BR    = 7'b1100011;
    localparam logic [1:0]  c_ALU_ADD  = 2'b00;
    localparam logic [1:0]  c_ALU_BR   = 2'b01;
    localparam logic [1:0]  c_ALU_R    = 2'b10;
    localparam logic [1:0]  c_ALU_I    = 2'b11;

    // Instruction fields
    logic [6:0]            w_opcode;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [2:0]            w_funct3;
    logic                  w_funct7b5;

    assign w_opcode   = if_id_instr[6:0];
    assign w_rs1      = if_id_instr[15 +: REG_ADDR_W];
    assign w_rs2      = if_id_instr[20 +: REG_ADDR_W];
    assign w_rd       = if_id_instr[7 +: REG_ADDR_W];
    assign w_funct3   = if_id_instr[14:12];
    assign w_funct7b5 = if_id_instr[30];

    // Register file
    logic [XLEN-1:0] r_regs [c_NREGS];
    logic            w_wb_en;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_wb_en = wb_reg_write && (wb_rd != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Write-through lets an instruction see the value being written back this cycle
    always_comb begin
        if (w_rs1 == '0) begin
            w_rs1_data = '0;
        end else if (w_wb_en && (wb_rd == w_rs1)) begin
            w_rs1_data = wb_data;
        end else begin
            w_rs1_data = r_regs[w_rs1];
        end
    end

    always_comb begin
        if (w_rs2 == '0) begin
            w_rs2_data = '0;
        end else if (w_wb_en && (wb_rd == w_rs2)) begin
            w_rs2_data = wb_data;
        end else begin
            w_rs2_data = r_regs[w_rs2];
        end
    end

    // Immediate formats, sign-extended from instr[31]
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;

    assign w_imm_i = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
    assign w_imm_b = {{(XLEN-13){if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                      if_id_instr[30:25], if_id_instr[11:8], 1'b0};

    // Main control decoder
    logic            w_reg_write;
    logic            w_mem_read;
    logic            w_mem_write;
    logic            w_mem_to_reg;
    logic            w_alu_src;
    logic            w_branch;
    logic [1:0]      w_alu_op;
    logic [XLEN-1:0] w_imm;
    logic            w_use_rs1;
    logic            w_use_rs2;

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_alu_op     = c_ALU_ADD;
        w_imm        = '0;
        w_use_rs1    = 1'b0;
        w_use_rs2    = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_reg_write = 1'b1;
                w_alu_op    = c_ALU_R;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
            end
            c_OP_IALU: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_op    = c_ALU_I;
                w_imm       = w_imm_i;
                w_use_rs1   = 1'b1;
            end
            c_OP_LOAD: begin
                w_reg_write  = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_alu_src    = 1'b1;
                w_alu_op     = c_ALU_ADD;
                w_imm        = w_imm_i;
                w_use_rs1    = 1'b1;
            end
            c_OP_STORE: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_op    = c_ALU_ADD;
                w_imm       = w_imm_s;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
            end
            c_OP_BR: begin
                w_branch  = 1'b1;
                w_alu_op  = c_ALU_BR;
                w_imm     = w_imm_b;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            default: begin
                w_alu_op = c_ALU_ADD;
            end
        endcase
    end

    // Load-use hazard: only operands the instruction actually reads can stall it
    logic w_hazard;

    assign w_hazard = id_ex_mem_read_in && (id_ex_rd_in != '0) &&
                      ((w_use_rs1 && (id_ex_rd_in == w_rs1)) ||
                       (w_use_rs2 && (id_ex_rd_in == w_rs2)));

    assign pc_write    = ~w_hazard;
    assign if_id_write = ~w_hazard;

    // ID/EX pipeline registers; flush and bubble both clear every field
    always_ff @(posedge clk) begin
        if (reset || flush_pipe || w_hazard) begin
            id_ex_pc         <= '0;
            id_ex_rs1_data   <= '0;
            id_ex_rs2_data   <= '0;
            id_ex_imm        <= '0;
            id_ex_rs1        <= '0;
            id_ex_rs2        <= '0;
            id_ex_rd         <= '0;
            id_ex_funct3     <= '0;
            id_ex_funct7b5   <= 1'b0;
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_branch     <= 1'b0;
            id_ex_alu_op     <= '0;
        end else begin
            id_ex_pc         <= if_id_pc;
            id_ex_rs1_data   <= w_rs1_data;
            id_ex_rs2_data   <= w_rs2_data;
            id_ex_imm        <= w_imm;
            id_ex_rs1        <= w_rs1;
            id_ex_rs2        <= w_rs2;
            id_ex_rd         <= w_rd;
            id_ex_funct3     <= w_funct3;
            id_ex_funct7b5   <= w_funct7b5;
            id_ex_reg_write  <= w_reg_write;
            id_ex_mem_read   <= w_mem_read;
            id_ex_mem_write  <= w_mem_write;
            id_ex_mem_to_reg <= w_mem_to_reg;
            id_ex_alu_src    <= w_alu_src;
            id_ex_branch     <= w_branch;
            id_ex_alu_op     <= w_alu_op;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_decode
// Description : Scoreboard bench for instruction_decode with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;

    localparam logic [5:0] C_R = 6'b100000;
    localparam logic [5:0] C_I = 6'b100010;
    localparam logic [5:0] C_L = 6'b110110;
    localparam logic [5:0] C_S = 6'b001010;
    localparam logic [5:0] C_B = 6'b000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_pipe = 1'b0;
    logic [31:0] if_id_pc = '0;
    logic [31:0] if_id_instr = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        id_ex_mem_read_in = 1'b0;
    logic [4:0]  id_ex_rd_in = '0;
    logic        pc_write, if_id_write;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_funct7b5;
    logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
    logic        id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch;
    logic [1:0]  id_ex_alu_op;

    instruction_decode #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .flush_pipe(flush_pipe),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_ex_mem_read_in(id_ex_mem_read_in), .id_ex_rd_in(id_ex_rd_in),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
        .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_funct3(id_ex_funct3), .id_ex_funct7b5(id_ex_funct7b5),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .id_ex_alu_src(id_ex_alu_src), .id_ex_branch(id_ex_branch),
        .id_ex_alu_op(id_ex_alu_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        pcw;
        logic        ifw;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
        logic [5:0]  ctrl;
        logic [1:0]  aluop;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    function automatic exp_t mk(logic pcw, logic ifw, logic [31:0] pc, logic [31:0] rs1d,
                                logic [31:0] rs2d, logic [31:0] imm, logic [4:0] rs1,
                                logic [4:0] rs2, logic [4:0] rd, logic [2:0] f3, logic f7,
                                logic [5:0] ctrl, logic [1:0] aluop);
        exp_t e;
        e.id = 0; e.pcw = pcw; e.ifw = ifw; e.pc = pc; e.rs1d = rs1d; e.rs2d = rs2d;
        e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.f3 = f3; e.f7 = f7;
        e.ctrl = ctrl; e.aluop = aluop;
        return e;
    endfunction

    function automatic exp_t zero_exp(logic pcw, logic ifw);
        return mk(pcw, ifw, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 6'd0, 2'd0);
    endfunction

    task automatic chk(input int id, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", id, name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the rising edge latches them into ID/EX
    task automatic drive(input logic rst, input logic fl, input logic [31:0] pc,
                         input logic [31:0] instr, input logic wbw, input logic [4:0] wbrd,
                         input logic [31:0] wbd, input logic mr, input logic [4:0] rdin,
                         input exp_t e);
        @(negedge clk);
        reset = rst; flush_pipe = fl; if_id_pc = pc; if_id_instr = instr;
        wb_reg_write = wbw; wb_rd = wbrd; wb_data = wbd;
        id_ex_mem_read_in = mr; id_ex_rd_in = rdin;
        e.id = step_id;
        step_id++;
        q.push_back(e);
    endtask

    // Monitor: inputs stay stable until the next falling edge, so the stall
    // outputs still describe the same instruction that was just latched
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.id, "pc_write",    {31'd0, pc_write},       {31'd0, e.pcw});
                chk(e.id, "if_id_write", {31'd0, if_id_write},    {31'd0, e.ifw});
                chk(e.id, "pc",          id_ex_pc,                e.pc);
                chk(e.id, "rs1_data",    id_ex_rs1_data,          e.rs1d);
                chk(e.id, "rs2_data",    id_ex_rs2_data,          e.rs2d);
                chk(e.id, "imm",         id_ex_imm,               e.imm);
                chk(e.id, "rs1",         {27'd0, id_ex_rs1},      {27'd0, e.rs1});
                chk(e.id, "rs2",         {27'd0, id_ex_rs2},      {27'd0, e.rs2});
                chk(e.id, "rd",          {27'd0, id_ex_rd},       {27'd0, e.rd});
                chk(e.id, "funct3",      {29'd0, id_ex_funct3},   {29'd0, e.f3});
                chk(e.id, "funct7b5",    {31'd0, id_ex_funct7b5}, {31'd0, e.f7});
                chk(e.id, "ctrl",
                    {26'd0, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
                     id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch},
                    {26'd0, e.ctrl});
                chk(e.id, "alu_op",      {30'd0, id_ex_alu_op},   {30'd0, e.aluop});
            end
        end
    end

    initial begin
        // Reset with a pending writeback to x3
        drive(1, 0, 32'h0, 32'h00A00293, 1, 5'd3, 32'h55, 0, 5'd0, zero_exp(1, 1));
        drive(1, 0, 32'h0, 32'h00A00293, 1, 5'd3, 32'h55, 0, 5'd0, zero_exp(1, 1));
        // addi x8,x3,0 : x3 must have stayed 0
        drive(0, 0, 32'h100, 32'h00018413, 0, 5'd0, 32'h0, 0, 5'd0,
              mk(1, 1, 32'h100, 0, 0, 0, 5'd3, 5'd0, 5'd8, 3'd0, 1'b0, C_I, 2'b11));
        // addi x5,x0,10 with x5 <= 0xA written back
        drive(0, 0, 32'h104, 32'h00A00293, 1, 5'd5, 32'hA, 0, 5'd0,
              mk(1, 1, 32'h104, 0, 0, 32'hA, 5'd0, 5'd10, 5'd5, 3'd0, 1'b0, C_I, 2'b11));
        // add x7,x6,x5 with x6 bypassed from writeback
        drive(0, 0, 32'h108, 32'h005303B3, 1, 5'd6, 32'h1234, 0, 5'd0,
              mk(1, 1, 32'h108, 32'h1234, 32'hA, 0, 5'd6, 5'd5, 5'd7, 3'd0, 1'b0, C_R, 2'b10));
        // add x9,x0,x0 while writing x0
        drive(0, 0, 32'h10C, 32'h000004B3, 1, 5'd0, 32'hDEAD, 0, 5'd0,
              mk(1, 1, 32'h10C, 0, 0, 0, 5'd0, 5'd0, 5'd9, 3'd0, 1'b0, C_R, 2'b10));
        drive(0, 0, 32'h110, 32'h000004B3, 0, 5'd0, 32'h0, 0, 5'd0,
              mk(1, 1, 32'h110, 0, 0, 0, 5'd0, 5'd0, 5'd9, 3'd0, 1'b0, C_R, 2'b10));
        // Load-use on rs1 -> stall and bubble
        drive(0, 0, 32'h114, 32'h005303B3, 0, 5'd0, 32'h0, 1, 5'd6, zero_exp(0, 0));
        // Load destination x0 never stalls
        drive(0, 0, 32'h118, 32'h005303B3, 0, 5'd0, 32'h0, 1, 5'd0,
              mk(1, 1, 32'h118, 32'h1234, 32'hA, 0, 5'd6, 5'd5, 5'd7, 3'd0, 1'b0, C_R, 2'b10));
        // Load-use on rs2
        drive(0, 0, 32'h11C, 32'h005303B3, 0, 5'd0, 32'h0, 1, 5'd5, zero_exp(0, 0));
        // I-type: rs2 field is immediate bits, so matching it must not stall
        drive(0, 0, 32'h120, 32'h00A00293, 0, 5'd0, 32'h0, 1, 5'd10,
              mk(1, 1, 32'h120, 0, 0, 32'hA, 5'd0, 5'd10, 5'd5, 3'd0, 1'b0, C_I, 2'b11));
        // sw x5,8(x2)
        drive(0, 0, 32'h124, 32'h00512423, 0, 5'd0, 32'h0, 0, 5'd0,
              mk(1, 1, 32'h124, 0, 32'hA, 32'h8, 5'd2, 5'd5, 5'd8, 3'd2, 1'b0, C_S, 2'b00));
        // beq x1,x2,-8
        drive(0, 0, 32'h128, 32'hFE208CE3, 0, 5'd0, 32'h0, 0, 5'd0,
              mk(1, 1, 32'h128, 0, 0, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 3'd0, 1'b1, C_B, 2'b01));
        // lw x11,-4(x5)
        drive(0, 0, 32'h12C, 32'hFFC2A583, 0, 5'd0, 32'h0, 0, 5'd0,
              mk(1, 1, 32'h12C, 32'hA, 0, 32'hFFFFFFFC, 5'd5, 5'd28, 5'd11, 3'd2, 1'b1, C_L, 2'b00));
        // sub x7,x6,x5
        drive(0, 0, 32'h130, 32'h405303B3, 0, 5'd0, 32'h0, 0, 5'd0,
              mk(1, 1, 32'h130, 32'h1234, 32'hA, 0, 5'd6, 5'd5, 5'd7, 3'd0, 1'b1, C_R, 2'b10));
        // Flush with concurrent hazard: ID/EX cleared, stall still reported
        drive(0, 1, 32'h134, 32'h00018413, 0, 5'd0, 32'h0, 1, 5'd3, zero_exp(0, 0));
        // Unknown opcode
        drive(0, 0, 32'h138, 32'h0000007F, 0, 5'd0, 32'h0, 0, 5'd0,
              mk(1, 1, 32'h138, 0, 0, 0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 6'd0, 2'b00));
        // Mid-run reset with a writeback to x12 that must be discarded
        drive(1, 0, 32'h13C, 32'h005303B3, 1, 5'd12, 32'h77, 0, 5'd0, zero_exp(1, 1));
        // add x13,x12,x5 : both cleared by the reset
        drive(0, 0, 32'h140, 32'h005606B3, 0, 5'd0, 32'h0, 0, 5'd0,
              mk(1, 1, 32'h140, 0, 0, 0, 5'd12, 5'd5, 5'd13, 3'd0, 1'b0, C_R, 2'b10));

        @(negedge clk);
        id_ex_mem_read_in = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk(-1, "scoreboard_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
